// File: rtl/pulse_sequencer.sv
// ---------------------------------------------------------------------------
// pulse_sequencer
//
// Programmable pulse-train generator. Period, high-time and burst count are
// sampled when a run is started and held for the whole run, so the control
// register block may rewrite them freely while a train is being produced.
//
// Modes (mode input, latched at start):
//   0 = continuous : periods repeat until stop
//   1 = burst      : max(burst_count,1) periods, then done
//   2 = single     : one period, then done
//   3 = single     : reserved alias of single
//
// Ports:
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   enable       advance enable; low freezes phase and remaining-period count
//   start        run request, only honoured while idle
//   stop         abort the current run (independent of enable)
//   mode         run mode, see above
//   period       period length in clock cycles (0 behaves as 1)
//   high_time    cycles the pulse is high at the start of each period
//   burst_count  periods per burst (0 behaves as 1)
//   pulse        pulse-train output
//   strobe       high on the last cycle of every period
//   busy         a run is in progress
//   done         one-cycle completion flag for burst/single runs
//
// Every output is a flop. The next-state logic also produces the next output
// values, so the outputs always agree with the state they are registered with
// and there is no path from an input straight to an output.
// ---------------------------------------------------------------------------
module pulse_sequencer #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high_time,
  input  logic [BURST_W-1:0] burst_count,
  output logic               pulse,
  output logic               strobe,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] MODE_CONT  = 2'd0;
  localparam logic [1:0] MODE_BURST = 2'd1;

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A zero period would make the wrap compare underflow; one cycle is the
  // shortest meaningful period.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p == '0) ? CNT_ONE : p;
  endfunction

  // A burst of zero periods is treated as a single period.
  function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] b);
    return (b == '0) ? BURST_ONE : b;
  endfunction

  // Number of periods a run of the given mode lasts. Continuous runs never
  // consult the counter, so it is simply left at zero for them.
  function automatic logic [BURST_W-1:0] run_length(input logic [1:0]         m,
                                                    input logic [BURST_W-1:0] b);
    if (m == MODE_CONT) begin
      return '0;
    end else if (m == MODE_BURST) begin
      return clamp_burst(b);
    end else begin
      return BURST_ONE;
    end
  endfunction

  // Registered state
  state_t             state;
  logic [CNT_W-1:0]   phase;
  logic [CNT_W-1:0]   period_r;
  logic [CNT_W-1:0]   high_r;
  logic [BURST_W-1:0] remaining;
  logic [1:0]         mode_r;

  // Next-state values
  state_t             state_n;
  logic [CNT_W-1:0]   phase_n;
  logic [CNT_W-1:0]   period_n;
  logic [CNT_W-1:0]   high_n;
  logic [BURST_W-1:0] remaining_n;
  logic [1:0]         mode_n;
  logic               pulse_n;
  logic               strobe_n;
  logic               busy_n;
  logic               done_n;

  logic accept;
  logic last_phase;

  // Start is only taken when nothing is running, the block is enabled and no
  // stop is being asserted at the same time.
  assign accept     = (state == IDLE) && start && enable && !stop;
  assign last_phase = (phase == period_r - CNT_ONE);

  // ---- next-state and next-output logic ----
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    period_n    = period_r;
    high_n      = high_r;
    remaining_n = remaining;
    mode_n      = mode_r;
    done_n      = 1'b0;

    if (state == IDLE) begin
      if (accept) begin
        state_n     = RUN;
        phase_n     = '0;
        period_n    = clamp_period(period);
        high_n      = high_time;
        remaining_n = run_length(mode, burst_count);
        mode_n      = mode;
      end
    end else begin
      if (stop) begin
        // Abort wins over wrap/completion and never reports done.
        state_n = IDLE;
        phase_n = '0;
      end else if (enable) begin
        if (last_phase) begin
          phase_n = '0;
          if (mode_r != MODE_CONT) begin
            if (remaining == BURST_ONE) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
            remaining_n = remaining - BURST_ONE;
          end
        end else begin
          phase_n = phase + CNT_ONE;
        end
      end
    end

    // Outputs are derived from the values about to be registered, so they
    // describe the cycle that follows the edge. period_n is never zero while
    // busy_n is set, so the strobe compare cannot underflow when it matters.
    busy_n   = (state_n == RUN);
    pulse_n  = busy_n && (phase_n < high_n);
    strobe_n = busy_n && (phase_n == period_n - CNT_ONE);
  end

  // ---- state and output registers ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      period_r  <= '0;
      high_r    <= '0;
      remaining <= '0;
      mode_r    <= '0;
      pulse     <= 1'b0;
      strobe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      period_r  <= period_n;
      high_r    <= high_n;
      remaining <= remaining_n;
      mode_r    <= mode_n;
      pulse     <= pulse_n;
      strobe    <= strobe_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pulse_sequencer
//
// Directed bench for pulse_sequencer. A cycle-count model (enabled cycles
// since start, total run length in cycles) predicts every output and is
// compared each negative clock edge; literal expectations worked out by hand
// pin the model at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_pulse_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [31:0] period;
  logic [31:0] high_time;
  logic [15:0] burst_count;
  logic        pulse;
  logic        strobe;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pulse_sequencer #(.CNT_W(32), .BURST_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .period      (period),
    .high_time   (high_time),
    .burst_count (burst_count),
    .pulse       (pulse),
    .strobe      (strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  bit     m_run  = 1'b0;
  bit     m_done = 1'b0;
  longint m_t    = 0;   // enabled cycles since the run started
  longint m_p    = 0;   // effective period
  longint m_h    = 0;   // high time
  longint m_tot  = 0;   // run length in cycles, 0 = endless

  function automatic longint eff_period(input logic [31:0] p);
    return (p == 0) ? 64'sd1 : longint'(p);
  endfunction

  function automatic longint eff_burst(input logic [15:0] b);
    return (b == 0) ? 64'sd1 : longint'(b);
  endfunction

  function automatic longint total_len(input logic [1:0] m, input logic [31:0] p,
                                       input logic [15:0] b);
    if (m == 2'd0) return 0;
    if (m == 2'd1) return eff_period(p) * eff_burst(b);
    return eff_period(p);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_t    <= 0;
      m_p    <= 0;
      m_h    <= 0;
      m_tot  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (start && enable && !stop) begin
          m_run <= 1'b1;
          m_t   <= 0;
          m_p   <= eff_period(period);
          m_h   <= longint'(high_time);
          m_tot <= total_len(mode, period, burst_count);
        end
      end else if (stop) begin
        m_run <= 1'b0;
      end else if (enable) begin
        if (m_tot != 0 && m_t + 1 == m_tot) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
        m_t <= m_t + 1;
      end
    end
  end

  function automatic logic exp_pulse();
    return m_run ? ((m_t % m_p) < m_h) : 1'b0;
  endfunction

  function automatic logic exp_strobe();
    return m_run ? ((m_t % m_p) == m_p - 1) : 1'b0;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("model_busy",   64'(busy),   64'(m_run));
      cmp("model_done",   64'(done),   64'(m_done));
      cmp("model_pulse",  64'(pulse),  64'(exp_pulse()));
      cmp("model_strobe", 64'(strobe), 64'(exp_strobe()));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  logic [9:0] pat_p;
  logic [9:0] pat_s;
  int n;
  int pc;
  int sc;

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
    mode = 2'd0; period = 0; high_time = 0; burst_count = 0;
    tick();
    chk_en = 1'b1;
    tick();
    cmp("rst_pulse",  64'(pulse),  64'd0);
    cmp("rst_strobe", 64'(strobe), 64'd0);
    cmp("rst_busy",   64'(busy),   64'd0);
    cmp("rst_done",   64'(done),   64'd0);

    reset = 1'b0;
    repeat (10) tick();
    cmp("idle_pulse", 64'(pulse), 64'd0);
    cmp("idle_busy",  64'(busy),  64'd0);

    // continuous, period 5, high 2
    mode = 2'd0; period = 5; high_time = 2; start = 1'b1;
    tick();
    start = 1'b0;
    pat_p = 10'b1100011000;
    pat_s = 10'b0000100001;
    for (int i = 0; i < 10; i++) begin
      cmp("cont_pulse",  64'(pulse),  64'(pat_p[9-i]));
      cmp("cont_strobe", 64'(strobe), 64'(pat_s[9-i]));
      cmp("cont_busy",   64'(busy),   64'd1);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cmp("cont_stop_busy", 64'(busy), 64'd0);
    cmp("cont_stop_done", 64'(done), 64'd0);

    // start together with stop while idle is ignored
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    cmp("start_stop_idle", 64'(busy), 64'd0);

    // burst, period 4, high 1, three periods
    mode = 2'd1; period = 4; high_time = 1; burst_count = 3; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; pc = 0;
    while (busy === 1'b1 && n < 40) begin
      if (pulse) pc++;
      n++;
      tick();
    end
    cmp("burst_busy_cycles", 64'(n), 64'd12);
    cmp("burst_pulses",      64'(pc), 64'd3);
    cmp("burst_done",        64'(done), 64'd1);
    start = 1'b1;                 // accepted in the done cycle
    tick();
    start = 1'b0;
    cmp("restart_busy", 64'(busy), 64'd1);
    cmp("restart_done", 64'(done), 64'd0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    cmp("restart_cycles", 64'(n), 64'd12);
    cmp("restart_done2",  64'(done), 64'd1);
    tick();
    cmp("done_one_cycle", 64'(done), 64'd0);

    // single, period 8, high 8, start pulses during the run ignored
    mode = 2'd2; period = 8; high_time = 8; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; pc = 0; sc = 0;
    while (busy === 1'b1 && n < 40) begin
      if (pulse) pc++;
      if (strobe) sc++;
      start = (n == 2 || n == 4);
      n++;
      tick();
    end
    start = 1'b0;
    cmp("single_cycles",  64'(n),  64'd8);
    cmp("single_pulses",  64'(pc), 64'd8);
    cmp("single_strobes", 64'(sc), 64'd1);
    cmp("single_done",    64'(done), 64'd1);
    tick();
    cmp("single_done_clr", 64'(done), 64'd0);
    cmp("single_idle",     64'(busy), 64'd0);

    // period 0, burst_count 0: one single-cycle period
    mode = 2'd1; period = 0; high_time = 1; burst_count = 0; start = 1'b1;
    tick();
    start = 1'b0;
    cmp("p0_busy",   64'(busy),   64'd1);
    cmp("p0_pulse",  64'(pulse),  64'd1);
    cmp("p0_strobe", 64'(strobe), 64'd1);
    tick();
    cmp("p0_end_busy",  64'(busy),  64'd0);
    cmp("p0_end_done",  64'(done),  64'd1);
    cmp("p0_end_pulse", 64'(pulse), 64'd0);
    tick();
    cmp("p0_done_clr", 64'(done), 64'd0);

    // high_time 0: no pulse, strobes continue
    mode = 2'd0; period = 3; high_time = 0; start = 1'b1;
    tick();
    start = 1'b0;
    pc = 0; sc = 0;
    for (int i = 0; i < 9; i++) begin
      if (pulse) pc++;
      if (strobe) sc++;
      tick();
    end
    cmp("h0_pulses",  64'(pc), 64'd0);
    cmp("h0_strobes", 64'(sc), 64'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // enable 1,0,0,1 during a single run of period 3
    mode = 2'd2; period = 3; high_time = 1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; pc = 0;
    while (busy === 1'b1 && n < 40) begin
      if (pulse) pc++;
      enable = (n == 1 || n == 2) ? 1'b0 : 1'b1;
      n++;
      tick();
    end
    enable = 1'b1;
    cmp("en_cycles", 64'(n),  64'd5);
    cmp("en_pulses", 64'(pc), 64'd1);
    cmp("en_done",   64'(done), 64'd1);
    enable = 1'b0;                // done still clears with enable low
    tick();
    cmp("en_done_clr", 64'(done), 64'd0);
    enable = 1'b1;

    // reset in the middle of a run
    mode = 2'd0; period = 5; high_time = 5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    cmp("pre_rst_busy",  64'(busy),  64'd1);
    cmp("pre_rst_pulse", 64'(pulse), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("mid_rst_busy",   64'(busy),   64'd0);
    cmp("mid_rst_pulse",  64'(pulse),  64'd0);
    cmp("mid_rst_strobe", 64'(strobe), 64'd0);
    cmp("mid_rst_done",   64'(done),   64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
